// File: rtl/fir_decim_buffer.sv
// Block-averaging decimator for the dvs_FIR output stream, feeding a small FWFT FIFO.
// Decimation factor follows low_power_mode; a mode change discards the current partial window.
module fir_decim_buffer #(
  parameter int DATA_W        = 16,
  parameter int LOG2_DECIM    = 2,
  parameter int LOG2_DECIM_LP = 3,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic signed [DATA_W-1:0]          filtered_data,
  input  logic                              sample_en,
  input  logic                              low_power_mode,
  output logic signed [DATA_W-1:0]          out_data,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [$clog2(FIFO_DEPTH):0]       fifo_level,
  output logic                              overflow,
  input  logic                              clear_ovf
);

  localparam int ACC_W = DATA_W + LOG2_DECIM_LP;
  localparam int CNT_W = (LOG2_DECIM_LP < 1) ? 1 : LOG2_DECIM_LP;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] LAST_N  = CNT_W'((1 << LOG2_DECIM) - 1);
  localparam logic [CNT_W-1:0] LAST_LP = CNT_W'((1 << LOG2_DECIM_LP) - 1);

  logic signed [ACC_W-1:0]  acc;
  logic signed [ACC_W-1:0]  sample_ext;
  logic signed [ACC_W-1:0]  sum;
  logic signed [DATA_W-1:0] avg;
  logic [CNT_W-1:0]         cnt;
  logic                     mode_q;
  logic                     mode_change;
  logic                     win_close;
  logic                     push;
  logic                     pop;
  logic                     full;
  logic                     accept;
  logic                     drop;
  logic [PTR_W-1:0]         wr_ptr;
  logic [PTR_W-1:0]         rd_ptr;
  logic [LVL_W-1:0]         level;
  logic signed [DATA_W-1:0] mem [FIFO_DEPTH];

  assign sample_ext  = {{LOG2_DECIM_LP{filtered_data[DATA_W-1]}}, filtered_data};
  assign sum         = acc + sample_ext;
  assign mode_change = (low_power_mode != mode_q);
  assign win_close   = (cnt == (mode_q ? LAST_LP : LAST_N));
  // Arithmetic shift floors toward -inf; the mean of DATA_W samples always fits DATA_W.
  assign avg         = DATA_W'(mode_q ? (sum >>> LOG2_DECIM_LP) : (sum >>> LOG2_DECIM));

  assign push   = sample_en && !mode_change && win_close;
  assign pop    = out_valid && out_ready;
  assign full   = (level == LVL_W'(FIFO_DEPTH));
  assign accept = push && (!full || pop);
  assign drop   = push && full && !pop;

  assign out_valid  = (level != '0);
  assign out_data   = out_valid ? mem[rd_ptr] : '0;
  assign fifo_level = level;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc      <= '0;
      cnt      <= '0;
      mode_q   <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      overflow <= 1'b0;
    end else begin
      if (mode_change) begin
        mode_q <= low_power_mode;
        acc    <= '0;
        cnt    <= '0;
      end else if (sample_en) begin
        if (win_close) begin
          acc <= '0;
          cnt <= '0;
        end else begin
          acc <= sum;
          cnt <= cnt + CNT_W'(1);
        end
      end

      if (accept) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)    rd_ptr <= rd_ptr + PTR_W'(1);

      if (accept && !pop)      level <= level + LVL_W'(1);
      else if (pop && !accept) level <= level - LVL_W'(1);

      // A drop in the same cycle as clear_ovf keeps the flag set.
      if (drop)           overflow <= 1'b1;
      else if (clear_ovf) overflow <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) mem[wr_ptr] <= avg;
  end

endmodule

// File: tb/tb_fir_decim_buffer.sv
// Directed bench for fir_decim_buffer: averaging, rounding, mode changes, FIFO full/overflow, async reset.
module tb_fir_decim_buffer;

  logic               clk;
  logic               reset;
  logic signed [15:0] filtered_data;
  logic               sample_en;
  logic               low_power_mode;
  logic signed [15:0] out_data;
  logic               out_valid;
  logic               out_ready;
  logic [2:0]         fifo_level;
  logic               overflow;
  logic               clear_ovf;

  int errors = 0;
  int checks = 0;

  fir_decim_buffer #(
    .DATA_W(16), .LOG2_DECIM(2), .LOG2_DECIM_LP(3), .FIFO_DEPTH(4)
  ) dut (
    .clk(clk),
    .reset(reset),
    .filtered_data(filtered_data),
    .sample_en(sample_en),
    .low_power_mode(low_power_mode),
    .out_data(out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .fifo_level(fifo_level),
    .overflow(overflow),
    .clear_ovf(clear_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One clock: present inputs, take the edge, return 1 time unit after it.
  task automatic cycle(input logic en, input logic signed [15:0] d);
    sample_en     = en;
    filtered_data = d;
    @(posedge clk);
    #1;
    sample_en     = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #2;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    checks++; if (out_valid !== 1'b0)  begin errors++; $display("FAIL rst_valid got %0b exp 0", out_valid); end
    checks++; if (out_data !== 16'sd0) begin errors++; $display("FAIL rst_data got %0d exp 0", out_data); end
    checks++; if (fifo_level !== 3'd0) begin errors++; $display("FAIL rst_level got %0d exp 0", fifo_level); end
    checks++; if (overflow !== 1'b0)   begin errors++; $display("FAIL rst_ovf got %0b exp 0", overflow); end
  endtask

  task automatic test_basic_avg();
    do_reset();
    low_power_mode = 1'b0; out_ready = 1'b1;
    cycle(1, 16'sd100); cycle(1, 16'sd200); cycle(1, 16'sd300);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL avg_early got %0b exp 0", out_valid); end
    cycle(1, 16'sd400);
    checks++; if (out_valid !== 1'b1)   begin errors++; $display("FAIL avg_valid got %0b exp 1", out_valid); end
    checks++; if (out_data !== 16'sd250) begin errors++; $display("FAIL avg_data got %0d exp 250", out_data); end
    cycle(0, 16'sd0);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL avg_onecycle got %0b exp 0", out_valid); end
  endtask

  task automatic test_floor();
    cycle(1, -16'sd1); cycle(1, -16'sd2); cycle(1, -16'sd2); cycle(1, -16'sd2);
    checks++; if (out_valid !== 1'b1)     begin errors++; $display("FAIL floor_valid got %0b exp 1", out_valid); end
    checks++; if (out_data !== 16'hFFFE) begin errors++; $display("FAIL floor_data got %h exp fffe", out_data); end
    cycle(0, 16'sd0);
  endtask

  task automatic test_lp_mode();
    logic early;
    do_reset();
    low_power_mode = 1'b1; out_ready = 1'b1;
    cycle(1, 16'h1234);
    early = 1'b0;
    for (int i = 0; i < 7; i++) begin
      cycle(1, 16'h1234);
      if (out_valid) early = 1'b1;
      cycle(0, 16'h7FFF);
      if (out_valid) early = 1'b1;
    end
    checks++; if (early !== 1'b0) begin errors++; $display("FAIL lp_early got %0b exp 0", early); end
    cycle(1, 16'h1234);
    checks++; if (out_valid !== 1'b1)     begin errors++; $display("FAIL lp_valid got %0b exp 1", out_valid); end
    checks++; if (out_data !== 16'h1234) begin errors++; $display("FAIL lp_data got %h exp 1234", out_data); end
    cycle(0, 16'sd0);
  endtask

  task automatic test_mode_change();
    logic early;
    do_reset();
    low_power_mode = 1'b0; out_ready = 1'b1;
    cycle(1, 16'sd1000); cycle(1, 16'sd1000);
    low_power_mode = 1'b1;
    cycle(1, 16'sd1000);
    early = out_valid;
    for (int i = 0; i < 7; i++) begin
      cycle(1, 16'sd8);
      if (out_valid) early = 1'b1;
    end
    checks++; if (early !== 1'b0) begin errors++; $display("FAIL mc_early got %0b exp 0", early); end
    cycle(1, 16'sd8);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL mc_valid got %0b exp 1", out_valid); end
    checks++; if (out_data !== 16'sd8) begin errors++; $display("FAIL mc_data got %0d exp 8", out_data); end
    cycle(0, 16'sd0);
    checks++; if (fifo_level !== 3'd0) begin errors++; $display("FAIL mc_level got %0d exp 0", fifo_level); end
  endtask

  task automatic test_overflow();
    do_reset();
    low_power_mode = 1'b0; out_ready = 1'b0; clear_ovf = 1'b0;
    for (int k = 1; k <= 4; k++)
      for (int j = 0; j < 4; j++) cycle(1, 16'(k));
    checks++; if (fifo_level !== 3'd4) begin errors++; $display("FAIL ovf_fill_level got %0d exp 4", fifo_level); end
    checks++; if (overflow !== 1'b0)   begin errors++; $display("FAIL ovf_fill_flag got %0b exp 0", overflow); end
    for (int j = 0; j < 4; j++) cycle(1, 16'sd5);
    checks++; if (fifo_level !== 3'd4) begin errors++; $display("FAIL ovf_level got %0d exp 4", fifo_level); end
    checks++; if (overflow !== 1'b1)   begin errors++; $display("FAIL ovf_flag got %0b exp 1", overflow); end
    for (int j = 0; j < 3; j++) cycle(1, 16'sd6);
    clear_ovf = 1'b1;
    cycle(1, 16'sd6);
    clear_ovf = 1'b0;
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_drop_wins got %0b exp 1", overflow); end
    out_ready = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      checks++; if (out_data !== 16'(k)) begin errors++; $display("FAIL ovf_drain%0d got %0d exp %0d", k, out_data, k); end
      cycle(0, 16'sd0);
    end
    checks++; if (fifo_level !== 3'd0) begin errors++; $display("FAIL ovf_drained got %0d exp 0", fifo_level); end
    checks++; if (overflow !== 1'b1)   begin errors++; $display("FAIL ovf_sticky got %0b exp 1", overflow); end
    clear_ovf = 1'b1;
    cycle(0, 16'sd0);
    clear_ovf = 1'b0;
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_clear got %0b exp 0", overflow); end
  endtask

  task automatic test_full_push_pop();
    do_reset();
    low_power_mode = 1'b0; out_ready = 1'b0;
    for (int k = 1; k <= 4; k++)
      for (int j = 0; j < 4; j++) cycle(1, 16'(10 * k));
    for (int j = 0; j < 3; j++) cycle(1, 16'sd50);
    out_ready = 1'b1;
    cycle(1, 16'sd50);
    out_ready = 1'b0;
    checks++; if (fifo_level !== 3'd4) begin errors++; $display("FAIL pp_level got %0d exp 4", fifo_level); end
    checks++; if (overflow !== 1'b0)   begin errors++; $display("FAIL pp_ovf got %0b exp 0", overflow); end
    out_ready = 1'b1;
    for (int k = 2; k <= 5; k++) begin
      checks++; if (out_data !== 16'(10 * k)) begin errors++; $display("FAIL pp_order%0d got %0d exp %0d", k, out_data, 10 * k); end
      cycle(0, 16'sd0);
    end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL pp_empty got %0b exp 0", out_valid); end
  endtask

  task automatic test_async_reset();
    do_reset();
    low_power_mode = 1'b0; out_ready = 1'b0;
    for (int j = 0; j < 4; j++) cycle(1, 16'sd100);
    cycle(1, 16'sd100); cycle(1, 16'sd100);
    checks++; if (fifo_level !== 3'd1) begin errors++; $display("FAIL ar_pre_level got %0d exp 1", fifo_level); end
    #2;
    reset = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0)  begin errors++; $display("FAIL ar_valid got %0b exp 0", out_valid); end
    checks++; if (fifo_level !== 3'd0) begin errors++; $display("FAIL ar_level got %0d exp 0", fifo_level); end
    #1;
    reset = 1'b0;
    cycle(1, 16'sd400); cycle(1, 16'sd400); cycle(1, 16'sd400);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL ar_partial got %0b exp 0", out_valid); end
    cycle(1, 16'sd400);
    checks++; if (out_valid !== 1'b1)    begin errors++; $display("FAIL ar_fresh_valid got %0b exp 1", out_valid); end
    checks++; if (out_data !== 16'sd400) begin errors++; $display("FAIL ar_fresh_data got %0d exp 400", out_data); end
  endtask

  initial begin
    reset = 1'b1; filtered_data = '0; sample_en = 1'b0;
    low_power_mode = 1'b0; out_ready = 1'b0; clear_ovf = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    reset = 1'b0;
    test_basic_avg();
    test_floor();
    test_lp_mode();
    test_mode_change();
    test_overflow();
    test_full_push_pop();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
